// File: rtl/store_write_buffer_if.sv
// CPU-side and memory-side bus of the store write buffer.
// slave: the buffer's view; master: the CPU/memory environment's view.
interface store_write_buffer_if #(
  parameter int unsigned N = 16,
  parameter int unsigned A = 16
);
  logic         cpu_Valid;
  logic         cpu_RW;
  logic [A-1:0] cpu_Address;
  logic [N-1:0] cpu_Dout;
  logic [N-1:0] cpu_Din;
  logic         stall;
  logic [A-1:0] mem_Address;
  logic         mem_RW;
  logic [N-1:0] mem_Dout;
  logic [N-1:0] mem_Din;

  modport slave (
    input  cpu_Valid, cpu_RW, cpu_Address, cpu_Dout, mem_Din,
    output cpu_Din, stall, mem_Address, mem_RW, mem_Dout
  );

  modport master (
    output cpu_Valid, cpu_RW, cpu_Address, cpu_Dout, mem_Din,
    input  cpu_Din, stall, mem_Address, mem_RW, mem_Dout
  );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-write buffer between CPU and memory: stores queue and drain on free port cycles.
// Optional macro WB_FORWARD_EN: loads hitting buffered stores are forwarded instead of stalled.
module store_write_buffer #(
  parameter int unsigned N        = 16,
  parameter int unsigned A        = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  store_write_buffer_if.slave  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [A-1:0] addr;
    logic [N-1:0] data;
  } entry_t;

  entry_t         buf_q [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           fwd_hit_q, fwd_hit_d;
  logic [N-1:0]   fwd_data_q, fwd_data_d;

  logic           rd_c, wr_c, nonempty_c, force_c;
  logic           match_c, stall_c, issue_c, pop_c, push_c;
  logic [N-1:0]   match_data_c;
  entry_t         head_entry_c;

  assign rd_c         = bus.cpu_Valid & bus.cpu_RW;
  assign wr_c         = bus.cpu_Valid & ~bus.cpu_RW;
  assign nonempty_c   = (count_q != '0);
  assign force_c      = (starve_q == SW'(MAX_WAIT)) & nonempty_c;
  assign head_entry_c = buf_q[head_q];

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    match_c      = 1'b0;
    match_data_c = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if ((CW'(k) < count_q) && (buf_q[head_q + PW'(k)].addr == bus.cpu_Address)) begin
        match_c      = 1'b1;
        match_data_c = buf_q[head_q + PW'(k)].data;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign stall_c   = reset & rd_c & force_c;
  assign fwd_hit_d = issue_c & match_c;
`else
  assign stall_c   = reset & rd_c & (force_c | match_c);
  assign fwd_hit_d = 1'b0;
`endif

  assign issue_c = reset & rd_c & ~stall_c;
  assign pop_c   = reset & ~issue_c & nonempty_c;
  assign push_c  = reset & wr_c;

  // Memory port arbitration; held idle while reset is low so no partial write escapes.
  always_comb begin
    bus.mem_RW      = 1'b1;
    bus.mem_Address = bus.cpu_Address;
    bus.mem_Dout    = '0;
    bus.stall       = stall_c;
    bus.cpu_Din     = fwd_hit_q ? fwd_data_q : bus.mem_Din;
    if (!reset) begin
      bus.mem_Address = '0;
      bus.cpu_Din     = '0;
    end else if (pop_c) begin
      bus.mem_RW      = 1'b0;
      bus.mem_Address = head_entry_c.addr;
      bus.mem_Dout    = head_entry_c.data;
    end
  end

  // Next-state for pointers, occupancy, starvation and forwarding registers.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    starve_d   = starve_q;
    fwd_data_d = fwd_data_q;
    if (push_c) tail_d = tail_q + PW'(1);
    if (pop_c)  head_d = head_q + PW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop_c || !nonempty_c) begin
      starve_d = '0;
    end else if (starve_q != SW'(MAX_WAIT)) begin
      starve_d = starve_q + SW'(1);
    end
    if (issue_c) fwd_data_d = match_data_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Entry storage needs no reset: occupancy alone defines which slots are valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      buf_q[tail_q] <= '{addr: bus.cpu_Address, data: bus.cpu_Dout};
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed, table-driven bench for store_write_buffer with a 64K-word memory model.
module tb_store_write_buffer;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  store_write_buffer_if #(.N(16), .A(16)) bus ();

  store_write_buffer #(.N(16), .A(16), .DEPTH(4), .MAX_WAIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: 1-cycle synchronous read (old data on same-cycle write), initial pattern addr^A5A5.
  logic [15:0] mem [65536];
  bit          init_done = 1'b0;
  int          wr_cnt    = 0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
      init_done <= 1'b1;
    end else if (!bus.mem_RW) begin
      mem[bus.mem_Address] <= bus.mem_Dout;
      wr_cnt <= wr_cnt + 1;
    end
    bus.mem_Din <= mem[bus.mem_Address];
  end

  typedef struct {
    logic        valid;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        exp_stall;
    logic        exp_mrw;
    logic [15:0] exp_maddr;
    logic [15:0] exp_mdout;
    logic        chk_din;
    logic [15:0] exp_din;
  } vec_t;

  localparam int unsigned NV = 30;
  vec_t vecs [NV];

  function automatic vec_t v(logic valid, logic rw, logic [15:0] addr, logic [15:0] dout,
                             logic st, logic mrw, logic [15:0] maddr, logic [15:0] mdout,
                             logic cd, logic [15:0] din);
    vec_t r;
    r.valid = valid; r.rw = rw; r.addr = addr; r.dout = dout;
    r.exp_stall = st; r.exp_mrw = mrw; r.exp_maddr = maddr; r.exp_mdout = mdout;
    r.chk_din = cd; r.exp_din = din;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic rw, input logic [15:0] addr,
                       input logic [15:0] dout);
    bus.cpu_Valid   = valid;
    bus.cpu_RW      = rw;
    bus.cpu_Address = addr;
    bus.cpu_Dout    = dout;
  endtask

  initial begin
    // Basic read, drain-on-idle, starvation drain, back-to-back stores, matching load.
    vecs[0]  = v(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000);
    vecs[1]  = v(1, 1, 16'h0010, 16'h0000, 0, 1, 16'h0010, 16'h0000, 0, 16'h0000);
    vecs[2]  = v(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 1, 16'hA5B5);
    vecs[3]  = v(1, 0, 16'h0020, 16'hBEEF, 0, 1, 16'h0020, 16'h0000, 0, 16'h0000);
    vecs[4]  = v(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0020, 16'hBEEF, 0, 16'h0000);
    vecs[5]  = v(1, 1, 16'h0020, 16'h0000, 0, 1, 16'h0020, 16'h0000, 0, 16'h0000);
    vecs[6]  = v(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 1, 16'hBEEF);
    vecs[7]  = v(1, 0, 16'h0100, 16'h0001, 0, 1, 16'h0100, 16'h0000, 0, 16'h0000);
    for (int i = 8; i < 16; i++)
      vecs[i] = v(1, 1, 16'h0010, 16'h0000, 0, 1, 16'h0010, 16'h0000, logic'(i > 8), 16'hA5B5);
    vecs[16] = v(1, 1, 16'h0010, 16'h0000, 1, 0, 16'h0100, 16'h0001, 1, 16'hA5B5);
    vecs[17] = v(1, 1, 16'h0010, 16'h0000, 0, 1, 16'h0010, 16'h0000, 0, 16'h0000);
    vecs[18] = v(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 1, 16'hA5B5);
    vecs[19] = v(1, 0, 16'h0101, 16'h0002, 0, 1, 16'h0101, 16'h0000, 0, 16'h0000);
    vecs[20] = v(1, 0, 16'h0102, 16'h0003, 0, 0, 16'h0101, 16'h0002, 0, 16'h0000);
    vecs[21] = v(1, 0, 16'h0103, 16'h0004, 0, 0, 16'h0102, 16'h0003, 0, 16'h0000);
    vecs[22] = v(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0103, 16'h0004, 0, 16'h0000);
    vecs[23] = v(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000);
    vecs[24] = v(1, 0, 16'h0200, 16'h1111, 0, 1, 16'h0200, 16'h0000, 0, 16'h0000);
    vecs[25] = v(1, 0, 16'h0200, 16'h2222, 0, 0, 16'h0200, 16'h1111, 0, 16'h0000);
`ifdef WB_FORWARD_EN
    vecs[26] = v(1, 1, 16'h0200, 16'h0000, 0, 1, 16'h0200, 16'h0000, 0, 16'h0000);
    vecs[27] = v(1, 1, 16'h0200, 16'h0000, 0, 1, 16'h0200, 16'h0000, 1, 16'h2222);
    vecs[28] = v(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0200, 16'h2222, 1, 16'h2222);
`else
    vecs[26] = v(1, 1, 16'h0200, 16'h0000, 1, 0, 16'h0200, 16'h2222, 0, 16'h0000);
    vecs[27] = v(1, 1, 16'h0200, 16'h0000, 0, 1, 16'h0200, 16'h0000, 0, 16'h0000);
    vecs[28] = v(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 1, 16'h2222);
`endif
    vecs[29] = v(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000);

    // Reset phase with a live read request on the bus.
    reset = 1'b0;
    drive(1, 1, 16'h1234, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    chk("rst stall",    16'(bus.stall),   16'h0000);
    chk("rst mem_RW",   16'(bus.mem_RW),  16'h0001);
    chk("rst mem_Addr", bus.mem_Address,  16'h0000);
    chk("rst mem_Dout", bus.mem_Dout,     16'h0000);
    chk("rst cpu_Din",  bus.cpu_Din,      16'h0000);
    reset = 1'b1;
    drive(0, 0, 16'h0000, 16'h0000);

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rw, vecs[i].addr, vecs[i].dout);
      #1;
      chk($sformatf("row%0d stall", i),    16'(bus.stall),  16'(vecs[i].exp_stall));
      chk($sformatf("row%0d mem_RW", i),   16'(bus.mem_RW), 16'(vecs[i].exp_mrw));
      chk($sformatf("row%0d mem_Addr", i), bus.mem_Address, vecs[i].exp_maddr);
      if (!vecs[i].exp_mrw)
        chk($sformatf("row%0d mem_Dout", i), bus.mem_Dout, vecs[i].exp_mdout);
      if (vecs[i].chk_din)
        chk($sformatf("row%0d cpu_Din", i), bus.cpu_Din, vecs[i].exp_din);
    end

    // Reset while an entry is buffered: the entry must never reach memory.
    @(negedge clk);
    drive(1, 0, 16'h0300, 16'h5555);
    #1;
    chk("pre-rst mem_RW", 16'(bus.mem_RW), 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 16'h0000, 16'h0000);
    #1;
    chk("mid-rst mem_RW",   16'(bus.mem_RW), 16'h0001);
    chk("mid-rst mem_Addr", bus.mem_Address, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst%0d mem_RW", i), 16'(bus.mem_RW), 16'h0001);
    end

    // Memory image: each store exactly once, in order, discarded entry absent.
    @(negedge clk);
    chk("mem writes",  16'(wr_cnt),  16'd7);
    chk("mem[0100]",   mem[16'h0100], 16'h0001);
    chk("mem[0101]",   mem[16'h0101], 16'h0002);
    chk("mem[0102]",   mem[16'h0102], 16'h0003);
    chk("mem[0103]",   mem[16'h0103], 16'h0004);
    chk("mem[0200]",   mem[16'h0200], 16'h2222);
    chk("mem[0300]",   mem[16'h0300], 16'hA6A5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
